// File: rtl/morph_filter_3x3_if.sv
// Pixel stream bundle for the 3x3 morphological filter: input pixels with frame marks and mode, filtered output stream, error flag.
// Latency: none; this is wiring only.
// Backpressure: none; the stream is valid-only, and the producer must respect the frame blanking contract.
interface morph_filter_3x3_if #(
   parameter int DATA_W = 10
);
   logic              iDVAL;
   logic              iSOF;
   logic [1:0]        iMODE;
   logic [DATA_W-1:0] input_data;
   logic              oDVAL;
   logic              oSOF;
   logic [DATA_W-1:0] output_data;
   logic              oERR;

   // Upstream pixel source / downstream sink side.
   modport master (
      output iDVAL, iSOF, iMODE, input_data,
      input  oDVAL, oSOF, output_data, oERR
   );

   // Filter side.
   modport slave (
      input  iDVAL, iSOF, iMODE, input_data,
      output oDVAL, oSOF, output_data, oERR
   );
endinterface

// File: rtl/morph_filter_3x3.sv
// 3x3 grey-scale erode/dilate/gradient/bypass filter with internal line buffers, edge padding and end-of-frame flush.
// Latency: output (r,c) is registered on the edge that accepts input (r+1,c+1); the last IMG_W+1 outputs drain one per clock.
// Backpressure: none; accepted pixels in FLUSH are dropped and flagged, and an early iSOF restarts the frame.
module morph_filter_3x3 #(
   parameter int DATA_W = 10,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input logic               CLOCK,
   input logic               RESET_N,
   morph_filter_3x3_if.slave pix
);
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     in_c, out_c, col_idx;
   logic [RW-1:0]     in_r, out_r;
   logic [1:0]        mode;
   logic              restart, shift, wr, emit, err_set;
   logic              in_last, out_last;
   logic [2:0]        row_ok, col_ok;
   logic [DATA_W-1:0] lb1 [IMG_W];
   logic [DATA_W-1:0] lb2 [IMG_W];
   logic [DATA_W-1:0] win [3][3];
   logic [DATA_W-1:0] nw  [3][3];
   logic [DATA_W-1:0] tap_min, tap_max, result;

   assign in_last  = (in_c == LAST_C) && (in_r == LAST_R);
   assign out_last = (out_c == LAST_C) && (out_r == LAST_R);
   // A restarting pixel is always column 0, whatever the stale counter says.
   assign col_idx  = restart ? '0 : in_c;

   // Frame sequencing: decide whether this cycle shifts the window, writes the line buffers and emits a pixel.
   always_comb begin
      state_nxt = state;
      restart   = 1'b0;
      shift     = 1'b0;
      wr        = 1'b0;
      emit      = 1'b0;
      err_set   = 1'b0;
      case (state)
         IDLE: begin
            if (pix.iDVAL && pix.iSOF) begin
               restart   = 1'b1;
               state_nxt = FILL;
            end
         end
         FILL: begin
            if (pix.iDVAL && pix.iSOF) begin
               restart = 1'b1;
               err_set = 1'b1;
            end else if (pix.iDVAL) begin
               shift = 1'b1;
               wr    = 1'b1;
               if (in_r == RW'(1) && in_c == CW'(1)) begin
                  emit      = 1'b1;
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            if (pix.iDVAL && pix.iSOF) begin
               restart   = 1'b1;
               err_set   = 1'b1;
               state_nxt = FILL;
            end else if (pix.iDVAL) begin
               shift = 1'b1;
               wr    = 1'b1;
               emit  = 1'b1;
               if (in_last) state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            // Line buffers are frozen here: the reads they still serve belong to the last two rows.
            shift   = 1'b1;
            emit    = 1'b1;
            err_set = pix.iDVAL;
            if (out_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (restart) begin
         shift = 1'b1;
         wr    = 1'b1;
      end
   end

   // Next window: newest column comes from the two line buffers and the incoming pixel; older columns shift left.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         nw[i][0] = win[i][1];
         nw[i][1] = win[i][2];
      end
      nw[0][2] = lb2[col_idx];
      nw[1][2] = lb1[col_idx];
      nw[2][2] = pix.input_data;
   end

   // Taps outside the frame are excluded, which is equivalent to all-ones padding for min and zero padding for max.
   always_comb begin
      row_ok  = {out_r != LAST_R, 1'b1, out_r != '0};
      col_ok  = {out_c != LAST_C, 1'b1, out_c != '0};
      tap_min = '1;
      tap_max = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            if (row_ok[i] && col_ok[j]) begin
               if (nw[i][j] < tap_min) tap_min = nw[i][j];
               if (nw[i][j] > tap_max) tap_max = nw[i][j];
            end
         end
      end
   end

   // Mode select; the centre tap is always in-frame so max never falls below min.
   always_comb begin
      case (mode)
         2'b00:   result = nw[1][1];
         2'b01:   result = tap_min;
         2'b10:   result = tap_max;
         default: result = tap_max - tap_min;
      endcase
   end

   // Window and line buffer storage; contents are masked until valid, so no reset is needed.
   always_ff @(posedge CLOCK) begin
      if (shift) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               win[i][j] <= nw[i][j];
         if (wr) begin
            lb1[col_idx] <= pix.input_data;
            lb2[col_idx] <= lb1[col_idx];
         end
      end
   end

   // State, raster counters, latched mode and registered outputs.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state           <= IDLE;
         in_c            <= '0;
         in_r            <= '0;
         out_c           <= '0;
         out_r           <= '0;
         mode            <= 2'b00;
         pix.oDVAL       <= 1'b0;
         pix.oSOF        <= 1'b0;
         pix.output_data <= '0;
         pix.oERR        <= 1'b0;
      end else begin
         state     <= state_nxt;
         pix.oDVAL <= emit;
         pix.oSOF  <= emit && (out_r == '0) && (out_c == '0);
         if (err_set) pix.oERR <= 1'b1;
         if (emit) pix.output_data <= result;
         if (restart) begin
            mode  <= pix.iMODE;
            in_c  <= CW'(1);
            in_r  <= '0;
            out_c <= '0;
            out_r <= '0;
         end else begin
            if (shift) begin
               if (in_c == LAST_C) begin
                  in_c <= '0;
                  in_r <= (in_r == LAST_R) ? '0 : in_r + RW'(1);
               end else begin
                  in_c <= in_c + CW'(1);
               end
            end
            if (emit) begin
               if (out_c == LAST_C) begin
                  out_c <= '0;
                  out_r <= (out_r == LAST_R) ? '0 : out_r + RW'(1);
               end else begin
                  out_c <= out_c + CW'(1);
               end
            end
         end
      end
   end
endmodule

// File: doc/morph_filter_3x3.md
Name: morph_filter_3x3

Overview:
- Parametrised 3x3 grey-scale morphological filter for the streaming pixel path: erosion (min), dilation (max), gradient (max-min) or bypass, selected per frame.
- Contains its own line buffers, row/column counters, frame-edge padding and end-of-frame flush.
- Sits between the sensor/colour-conversion stage and downstream threshold/display blocks, replacing fixed single-mode dilation/erosion instances.

Parameters:
- DATA_W, 10, pixel width in bits.
- IMG_W, 640, active pixels per line (≥4).
- IMG_H, 480, active lines per frame (≥3).

Ports:
- CLOCK  in  1  pixel clock.
- RESET_N  in  1  asynchronous active-low reset.
- iDVAL  in  1  input pixel valid.
- iSOF  in  1  start of frame; qualified by iDVAL; marks pixel (0,0).
- iMODE  in  2  00 bypass, 01 erode, 10 dilate, 11 gradient.
- input_data  in  DATA_W  input pixel.
- oDVAL  out  1  output pixel valid.
- oSOF  out  1  marks output pixel (0,0).
- output_data  out  DATA_W  filtered pixel.
- oERR  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs 0. Counters 0, state IDLE. Line buffers are not reset; their contents are never used before being written.
- Raster order: pixels arrive row-major, with gaps (iDVAL low) allowed anywhere. Counters advance only on accepted pixels, i.e. iDVAL=1.
- Pixels accepted while in IDLE without iSOF are discarded.
- Mode: iMODE is sampled on the accepted iSOF pixel and held for the whole frame. Changes mid-frame are ignored.
- Window: output (r,c) uses input rows r-1..r+1 and columns c-1..c+1.
- Out-of-frame padding values:
  - Erode: all-ones.
  - Dilate: zero.
  - Gradient: max term padded zero, min term padded all-ones.
  - Frame corners and edges therefore never bias the result.
- Arithmetic:
  - Erode: min of 9 taps.
  - Dilate: max of 9 taps.
  - Gradient: max-min; unsigned, never negative, DATA_W bits.
  - Bypass: centre tap.
- Latency: output (r,c) is produced one clock after accepting input (r+1,c+1), using the row-below/column-right neighbour.
  - On the last row (r=IMG_H-1) and last column (c=IMG_W-1), padding substitutes for the missing neighbours.
  - oDVAL pulses once per output pixel. Exactly IMG_W*IMG_H outputs are produced per frame.
- FSM:
  - IDLE -> FILL on accepted iSOF.
  - FILL: accept pixels and emit nothing until input (1,1) is accepted. Then -> RUN; that acceptance emits output (0,0) with oSOF=1.
  - RUN: each accepted pixel emits one output. After input (IMG_H-1,IMG_W-1) is accepted -> FLUSH.
  - FLUSH: emit the remaining IMG_W+1 outputs autonomously, one per clock, regardless of iDVAL. Then -> IDLE.
- Errors (each sets oERR, sticky until reset):
  - Accepted pixel during FLUSH: pixel discarded, flush continues.
  - iSOF accepted in FILL or RUN: frame restarts from (0,0); the partial frame is dropped without flush.
- Upstream contract: at least IMG_W+2 blanking cycles after the last pixel of a frame.
- Reset mid-frame: immediate return to IDLE with outputs 0. The next frame must begin with iSOF.

Test Plan:
- IMG_W=4, IMG_H=3, dilate, all pixels 0 except (1,2)=0x3FF, continuous iDVAL -> 12 outputs. Output =0x3FF at rows 0..2, cols 1..3; 0 elsewhere. oSOF with first output. Last output IMG_W+1=5 clocks after last input.
- Same image, erode, all pixels 0x200 except (0,0)=0x010 -> outputs (0,0),(0,1),(1,0),(1,1)=0x010. Others 0x200; edges not pulled to 0.
- Gradient, ramp input = c*16 -> interior outputs 32; column 0 and column IMG_W-1 outputs 16. Never negative.
- Random iDVAL gaps (~50%), bypass -> output stream equals input stream pixel-for-pixel. Count=12, oERR=0.
- Erode mode latched, iMODE switched to dilate mid-frame -> whole frame still eroded. Next frame's iSOF picks up dilate.
- Error and recovery cases:
  - Second iSOF at pixel (1,2) -> oERR=1, frame restarts, 12 clean outputs follow.
  - RESET_N low during FLUSH -> all outputs 0 immediately; next frame correct.
